// File: rtl/rst_set_seq.sv
// rst_set_seq: async-assert / sync-release reset and set sequencer.
// Set path compiled in only when RST_SET_SEQ_SET_EN is defined.
module rst_set_seq #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RST_STRETCH = 16,
   parameter int unsigned SET_MIN     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_req_n,
   output logic rst_n_o,
   output logic set_n_o,
   output logic ready
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_HOLD,
      ST_IDLE,
      ST_SET_ACT,
      ST_GUARD
   } state_e;

   localparam logic [7:0] RST_LOAD = 8'(RST_STRETCH - 1);

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] rsync_q;
   logic                   rsync_out;
   logic                   rst_n_o_q, rst_n_o_d;
   logic                   ready_q, ready_d;

   // Reset release synchronizer: clears async, fills with ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsync_q <= '0;
      end else begin
         rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rsync_out = rsync_q[SYNC_STAGES-1];

`ifdef RST_SET_SEQ_SET_EN
   localparam logic [7:0] SET_LOAD = 8'(SET_MIN - 1);

   logic [SYNC_STAGES-1:0] ssync_q;
   logic                   sreq_n;
   logic                   set_n_o_q, set_n_o_d;

   // Set request synchronizer: idles high, samples the raw request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ssync_q <= '1;
      end else begin
         ssync_q <= {ssync_q[SYNC_STAGES-2:0], set_req_n};
      end
   end

   assign sreq_n = ssync_q[SYNC_STAGES-1];
`else
   logic unused_set_req;

   assign unused_set_req = set_req_n;
`endif

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         cnt_q     <= 8'd0;
         rst_n_o_q <= 1'b0;
         ready_q   <= 1'b0;
`ifdef RST_SET_SEQ_SET_EN
         set_n_o_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_n_o_q <= rst_n_o_d;
         ready_q   <= ready_d;
`ifdef RST_SET_SEQ_SET_EN
         set_n_o_q <= set_n_o_d;
`endif
      end
   end

   // Next state and counter; HOLD leaves on the edge the count hits 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RESET: begin
            if (rsync_out) begin
               if (RST_LOAD == 8'd0) begin
                  state_d = ST_GUARD;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = RST_LOAD;
               end
            end
         end
         ST_HOLD: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
`ifdef RST_SET_SEQ_SET_EN
            if (!sreq_n) begin
               state_d = ST_SET_ACT;
               cnt_d   = SET_LOAD;
            end
`endif
         end
`ifdef RST_SET_SEQ_SET_EN
         ST_SET_ACT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (sreq_n) begin
               state_d = ST_GUARD;
            end
         end
`endif
         default: begin
            state_d = ST_RESET;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Output values follow the state being entered
   always_comb begin
      rst_n_o_d = !((state_d == ST_RESET) || (state_d == ST_HOLD));
      ready_d   = (state_d == ST_IDLE);
`ifdef RST_SET_SEQ_SET_EN
      set_n_o_d = (state_d != ST_SET_ACT);
`endif
   end

   assign rst_n_o = rst_n_o_q;
   assign ready   = ready_q;
`ifdef RST_SET_SEQ_SET_EN
   assign set_n_o = set_n_o_q;
`else
   assign set_n_o = 1'b1;
`endif

endmodule
